// File: rtl/ahb_sram_slave_if.sv
// rtl/ahb_sram_slave_if.sv - AHB-Lite bus bundle between the master side and ahb_sram_slave
interface ahb_sram_slave_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;

  modport master (
    output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM slave with wait states, write forwarding and optional ERROR response
// Optional alignment/size checking is enabled by defining AHB_SRAM_ALIGN_CHECK_EN.
module ahb_sram_slave #(
  parameter int MEMWIDTH    = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  ahb_sram_slave_if.slave bus
);

  localparam int AW          = MEMWIDTH - 2;
  localparam int DEPTH       = 2 ** AW;
  localparam int WAIT_LOAD_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [2:0] WAIT_LOAD = WAIT_LOAD_I[2:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [2:0]    wait_cnt;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic [3:0]    strb_q;
  logic [31:0]   rdata_q;
  logic          hreadyout;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          take;
  logic          commit;
  logic [AW-1:0] acc_addr;
  logic [3:0]    acc_strb;
  logic          acc_err;
  logic [31:0]   rd_word;
  logic [31:0]   fwd_word;

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.HTRANS[0], bus.HADDR[31:MEMWIDTH]};

  assign accept   = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  // hreadyout is high only in IDLE/DATA/ERR2, the states that may open a new transfer
  assign take     = accept & hreadyout;
  assign acc_addr = bus.HADDR[MEMWIDTH-1:2];
  assign commit   = (state == S_DATA) && write_q;

  always_comb begin
    acc_strb = 4'b1111;
    case (bus.HSIZE)
      3'b000:  acc_strb = 4'b0001 << bus.HADDR[1:0];
      3'b001:  acc_strb = bus.HADDR[1] ? 4'b1100 : 4'b0011;
      default: acc_strb = 4'b1111;
    endcase
  end

`ifdef AHB_SRAM_ALIGN_CHECK_EN
  always_comb begin
    acc_err = 1'b0;
    case (bus.HSIZE)
      3'b000:  acc_err = 1'b0;
      3'b001:  acc_err = bus.HADDR[0];
      3'b010:  acc_err = |bus.HADDR[1:0];
      default: acc_err = 1'b1;
    endcase
  end

  assign bus.HRESP = ((state == S_ERR1) || (state == S_ERR2)) ? 2'b01 : 2'b00;
`else
  assign acc_err   = 1'b0;
  assign bus.HRESP = 2'b00;
`endif

  // A read taken on the edge a write to the same word commits must see the new lanes
  always_comb begin
    rd_word  = mem[acc_addr];
    fwd_word = rd_word;
    if (commit && (addr_q == acc_addr)) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) fwd_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_next = state;
    hreadyout  = 1'b1;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (accept) begin
          if (acc_err)              state_next = S_ERR1;
          else if (WAIT_STATES > 0) state_next = S_WAIT;
          else                      state_next = S_DATA;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        hreadyout = 1'b0;
        if (wait_cnt == 3'd0) state_next = S_DATA;
      end
      S_ERR1: begin
        hreadyout  = 1'b0;
        state_next = S_ERR2;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      wait_cnt <= 3'd0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      strb_q   <= 4'b0000;
      rdata_q  <= 32'h0;
    end else begin
      state <= state_next;
      if ((state == S_WAIT) && (wait_cnt != 3'd0)) wait_cnt <= wait_cnt - 3'd1;
      if (take) begin
        addr_q   <= acc_addr;
        write_q  <= bus.HWRITE & ~acc_err;
        strb_q   <= acc_strb;
        wait_cnt <= WAIT_LOAD;
        rdata_q  <= (bus.HWRITE || acc_err) ? 32'h0 : fwd_word;
      end
    end
  end

  // Array is deliberately left out of reset; a write still pending at reset is dropped
  always_ff @(posedge HCLK) begin
    if (HRESETn && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) mem[addr_q][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRDATA    = rdata_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - self-checking bench for ahb_sram_slave with 0 and 3 wait states
module tb_ahb_sram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  ahb_sram_slave_if bus0 ();
  ahb_sram_slave_if bus1 ();

  ahb_sram_slave #(.MEMWIDTH(12), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(resetn), .bus(bus0.slave)
  );
  ahb_sram_slave #(.MEMWIDTH(12), .WAIT_STATES(3)) dut1 (
    .HCLK(clk), .HRESETn(resetn), .bus(bus1.slave)
  );

  int          sel;
  logic        d_hsel;
  logic [31:0] d_haddr;
  logic [1:0]  d_htrans;
  logic        d_hwrite;
  logic [2:0]  d_hsize;
  logic [31:0] d_hwdata;

  assign bus0.HSEL   = (sel == 0) & d_hsel;
  assign bus1.HSEL   = (sel == 1) & d_hsel;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus1.HREADY = bus1.HREADYOUT;
  assign bus0.HADDR  = d_haddr;
  assign bus1.HADDR  = d_haddr;
  assign bus0.HTRANS = d_htrans;
  assign bus1.HTRANS = d_htrans;
  assign bus0.HWRITE = d_hwrite;
  assign bus1.HWRITE = d_hwrite;
  assign bus0.HSIZE  = d_hsize;
  assign bus1.HSIZE  = d_hsize;
  assign bus0.HWDATA = d_hwdata;
  assign bus1.HWDATA = d_hwdata;

  logic        o_ready;
  logic [1:0]  o_resp;
  logic [31:0] o_rdata;
  assign o_ready = (sel == 0) ? bus0.HREADYOUT : bus1.HREADYOUT;
  assign o_resp  = (sel == 0) ? bus0.HRESP     : bus1.HRESP;
  assign o_rdata = (sel == 0) ? bus0.HRDATA    : bus1.HRDATA;

  typedef struct packed {
    logic        rdy;
    logic [1:0]  resp;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic [7:0]  mem_m [2][4096];
  exp_t        expq[$];
  int          n_checks;
  int          n_fail;
  int          low_cnt;
  logic [31:0] last_rd;
  bit          cmp_en;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (cmp_en) begin
      if (expq.size() > 0) e = expq.pop_front();
      else e = '{rdy: 1'b1, resp: 2'b00, chk: 1'b0, data: 32'h0};
      check("hreadyout", {31'h0, o_ready}, {31'h0, e.rdy});
      check("hresp", {30'h0, o_resp}, {30'h0, e.resp});
      if (e.chk) begin
        check("hrdata", o_rdata, e.data);
        last_rd = o_rdata;
      end
      if (!o_ready) low_cnt++;
    end
  end

  // Model: bytes land immediately in issue order, so forwarding is implied by sequential semantics
  task automatic issue(bit wr, logic [31:0] addr, logic [2:0] size, logic [31:0] wdata);
    int n, base, wb, len, ws;
    bit err;
    exp_t e;
    logic [31:0] rd;
    n    = (size >= 3'd2) ? 4 : (1 << size);
    base = int'(addr[11:0]) & ~(n - 1);
    wb   = int'(addr[11:0]) & ~3;
`ifdef AHB_SRAM_ALIGN_CHECK_EN
    err = (size > 3'd2) || ((int'(addr[11:0]) % n) != 0);
`else
    err = 1'b0;
`endif
    d_hsel = 1'b1; d_htrans = 2'b10; d_haddr = addr; d_hwrite = wr; d_hsize = size;
    @(posedge clk); #1;
    d_hsel = 1'b0; d_htrans = 2'b00; d_hwdata = wdata;
    if (wr && !err) begin
      for (int k = 0; k < n; k++) mem_m[sel][base + k] = wdata[8*((base + k) % 4) +: 8];
    end
    rd = err ? 32'h0 : {mem_m[sel][wb+3], mem_m[sel][wb+2], mem_m[sel][wb+1], mem_m[sel][wb]};
    ws  = (sel == 1) ? 3 : 0;
    len = err ? 2 : ws + 1;
    for (int i = 0; i < len; i++) begin
      e.rdy  = (i == len - 1);
      e.resp = err ? 2'b01 : 2'b00;
      e.chk  = !wr;
      e.data = rd;
      expq.push_back(e);
    end
    repeat (len - 1) begin @(posedge clk); #1; end
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic noxfer(logic hsel, logic [1:0] tr);
    d_hsel = hsel; d_htrans = tr; d_haddr = 32'h50; d_hwrite = 1'b1;
    d_hsize = 3'b010; d_hwdata = 32'h0BAD0BAD;
    @(posedge clk); #1;
    d_hsel = 1'b0; d_htrans = 2'b00;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sel = 0; resetn = 1'b0; cmp_en = 1'b0;
    d_hsel = 1'b0; d_haddr = 32'h0; d_htrans = 2'b00; d_hwrite = 1'b0;
    d_hsize = 3'b000; d_hwdata = 32'h0;
    n_checks = 0; n_fail = 0; low_cnt = 0; last_rd = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst0_hreadyout", {31'h0, bus0.HREADYOUT}, 32'h1);
    check("rst0_hresp", {30'h0, bus0.HRESP}, 32'h0);
    check("rst0_hrdata", bus0.HRDATA, 32'h0);
    check("rst1_hreadyout", {31'h0, bus1.HREADYOUT}, 32'h1);
    check("rst1_hrdata", bus1.HRDATA, 32'h0);
    resetn = 1'b1;
    cmp_en = 1'b1;
    idle(1);

    issue(1, 32'h10, 3'b010, 32'hDEADBEEF);
    issue(0, 32'h10, 3'b010, 32'h0);
    idle(1);
    check("pin_word_rd", last_rd, 32'hDEADBEEF);

    issue(1, 32'h20, 3'b010, 32'h0);
    issue(1, 32'h21, 3'b000, 32'h00001100);
    issue(1, 32'h23, 3'b000, 32'h22000000);
    issue(0, 32'h20, 3'b010, 32'h0);
    idle(1);
    check("pin_byte_lanes", last_rd, 32'h22001100);

    issue(1, 32'h40, 3'b010, 32'h12345678);
    idle(1);
    issue(1, 32'h42, 3'b001, 32'hABCD0000);
    issue(0, 32'h40, 3'b010, 32'h0);
    idle(1);
    check("pin_forward_half", last_rd, 32'hABCD5678);

    issue(1, 32'h1050, 3'b010, 32'hCAFEF00D);
    issue(0, 32'h0050, 3'b010, 32'h0);
    noxfer(1'b1, 2'b01);
    noxfer(1'b1, 2'b00);
    noxfer(1'b0, 2'b10);
    issue(0, 32'h0050, 3'b010, 32'h0);
    idle(1);
    check("pin_alias_noxfer", last_rd, 32'hCAFEF00D);

    issue(1, 32'h04, 3'b010, 32'h01020304);
    issue(1, 32'h05, 3'b010, 32'hA5A5A5A5);
    issue(0, 32'h04, 3'b010, 32'h0);
    idle(1);
`ifdef AHB_SRAM_ALIGN_CHECK_EN
    check("pin_misalign_word", last_rd, 32'h01020304);
`else
    check("pin_misalign_word", last_rd, 32'hA5A5A5A5);
`endif
    issue(0, 32'h06, 3'b010, 32'h0);
    issue(1, 32'h08, 3'b010, 32'h11111111);
    issue(1, 32'h08, 3'b011, 32'h77665544);
    issue(1, 32'h0D, 3'b001, 32'h0000BEEF);
    issue(0, 32'h08, 3'b010, 32'h0);
    issue(0, 32'h0C, 3'b010, 32'h0);
    idle(2);
    check("zero_wait_never_low", low_cnt, 32'd0);

    sel = 1;
    idle(1);
    issue(1, 32'h80, 3'b010, 32'h55AA33CC);
    idle(1);
    low_cnt = 0;
    issue(0, 32'h80, 3'b010, 32'h0);
    idle(1);
    check("pin_ws3_low_cycles", low_cnt, 32'd3);
    check("pin_ws3_rd", last_rd, 32'h55AA33CC);

    issue(1, 32'h84, 3'b010, 32'h0F0E0D0C);
    issue(1, 32'h86, 3'b000, 32'h00990000);
    issue(0, 32'h84, 3'b010, 32'h0);
    issue(0, 32'h80, 3'b010, 32'h0);
    idle(1);
    check("pin_ws3_b2b", last_rd, 32'h55AA33CC);
    issue(0, 32'h85, 3'b000, 32'h0);
    idle(1);
    check("pin_ws3_fwd_byte", last_rd, 32'h0F990D0C);

    d_hsel = 1'b1; d_htrans = 2'b10; d_haddr = 32'h80; d_hwrite = 1'b1; d_hsize = 3'b010;
    @(posedge clk); #1;
    d_hsel = 1'b0; d_htrans = 2'b00; d_hwdata = 32'hFFFFFFFF;
    expq.push_back('{rdy: 1'b0, resp: 2'b00, chk: 1'b0, data: 32'h0});
    resetn = 1'b0;
    @(posedge clk); #1;
    check("midrst_hreadyout", {31'h0, bus1.HREADYOUT}, 32'h1);
    check("midrst_hresp", {30'h0, bus1.HRESP}, 32'h0);
    check("midrst_hrdata", bus1.HRDATA, 32'h0);
    resetn = 1'b1;
    idle(1);
    issue(0, 32'h80, 3'b010, 32'h0);
    idle(1);
    check("pin_rst_drop_write", last_rd, 32'h55AA33CC);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
